// File: rtl/fpu_exp_pkg.sv
// Shared constants and helpers for the FPU exponent adjust path.
package fpu_exp_pkg;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Largest biased exponent for an ew-bit field (all ones).
  function automatic int unsigned exp_max(input int unsigned ew);
    return (32'd1 << ew) - 32'd1;
  endfunction

endpackage : fpu_exp_pkg

// File: rtl/exp_sat_core.sv
// Combinational saturation of a raw (EW+1)-bit adjusted exponent.
// Ports:
//   r_i   raw adjusted exponent including the borrow/carry bit
//   op_i  OP_SUB / OP_ADD, selects the saturation rule
//   exp_o saturated exponent
//   uf_o  underflow (exp_o forced to zero)
//   of_o  overflow (exp_o forced to all-ones)
module exp_sat_core
  import fpu_exp_pkg::*;
#(
  parameter int unsigned EW = 8
) (
  input  logic [EW:0]   r_i,
  input  logic          op_i,
  output logic [EW-1:0] exp_o,
  output logic          uf_o,
  output logic          of_o
);

  localparam logic [EW:0] R_MAX = (EW+1)'(exp_max(EW));

  // Sub underflows on borrow (top bit set) or exact zero; add overflows at or
  // above the all-ones exponent, which is reserved for Inf/NaN.
  always_comb begin
    exp_o = r_i[EW-1:0];
    uf_o  = 1'b0;
    of_o  = 1'b0;
    if (op_i == OP_SUB) begin
      if (r_i[EW] || (r_i == '0)) begin
        uf_o  = 1'b1;
        exp_o = '0;
      end
    end else if (r_i >= R_MAX) begin
      of_o  = 1'b1;
      exp_o = '1;
    end
  end

endmodule : exp_sat_core

// File: rtl/exp_adjust_pipe.sv
// Two-stage pipelined exponent adjust with saturation and sticky status.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   exp_in, shamt, op   biased exponent, shift amount, OP_SUB/OP_ADD
//   out_valid/out_ready downstream handshake
//   exp_out, uf, of     saturated result and flags (held while stalled)
//   sticky_uf/of        accumulated flags from departed results
//   clr_sticky          synchronous clear of both sticky flags (set wins)
module exp_adjust_pipe
  import fpu_exp_pkg::*;
#(
  parameter int unsigned EW = 8,
  parameter int unsigned SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] exp_in,
  input  logic [SW-1:0] shamt,
  input  logic          op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] exp_out,
  output logic          uf,
  output logic          of,
  output logic          sticky_uf,
  output logic          sticky_of,
  input  logic          clr_sticky
);

  // Stage 1: raw result with borrow/carry bit
  logic          s1_valid_q, s1_valid_d;
  logic [EW:0]   s1_r_q, s1_r_d;
  logic          s1_op_q, s1_op_d;

  // Stage 2: saturated result and flags
  logic          s2_valid_q, s2_valid_d;
  logic [EW-1:0] s2_exp_q, s2_exp_d;
  logic          s2_uf_q, s2_uf_d;
  logic          s2_of_q, s2_of_d;

  logic          sticky_uf_q, sticky_uf_d;
  logic          sticky_of_q, sticky_of_d;

  logic          s1_adv, s2_adv;
  logic          in_xfer, out_xfer;
  logic [EW:0]   exp_ext, sh_ext;
  logic [EW-1:0] sat_exp;
  logic          sat_uf, sat_of;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid && s1_adv;
  assign out_xfer = s2_valid_q && out_ready;

  assign exp_ext = (EW+1)'(exp_in);
  assign sh_ext  = (EW+1)'(shamt);

  exp_sat_core #(.EW(EW)) u_sat (
    .r_i   (s1_r_q),
    .op_i  (s1_op_q),
    .exp_o (sat_exp),
    .uf_o  (sat_uf),
    .of_o  (sat_of)
  );

  // Next-state for both stages and the sticky flags
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_r_d      = s1_r_q;
    s1_op_d     = s1_op_q;
    s2_valid_d  = s2_valid_q;
    s2_exp_d    = s2_exp_q;
    s2_uf_d     = s2_uf_q;
    s2_of_d     = s2_of_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op;
        s1_r_d  = (op == OP_ADD) ? (exp_ext + sh_ext) : (exp_ext - sh_ext);
      end
    end

    // Stage-2 data only reloads on a real hand-over so a drained output keeps
    // its last value instead of picking up stale stage-1 contents.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_exp_d = sat_exp;
        s2_uf_d  = sat_uf;
        s2_of_d  = sat_of;
      end
    end

    // A flag-setting transfer overrides a coincident clear.
    sticky_uf_d = (sticky_uf_q && !clr_sticky) || (out_xfer && s2_uf_q);
    sticky_of_d = (sticky_of_q && !clr_sticky) || (out_xfer && s2_of_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      s1_op_q     <= OP_SUB;
      s2_valid_q  <= 1'b0;
      s2_exp_q    <= '0;
      s2_uf_q     <= 1'b0;
      s2_of_q     <= 1'b0;
      sticky_uf_q <= 1'b0;
      sticky_of_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      s1_op_q     <= s1_op_d;
      s2_valid_q  <= s2_valid_d;
      s2_exp_q    <= s2_exp_d;
      s2_uf_q     <= s2_uf_d;
      s2_of_q     <= s2_of_d;
      sticky_uf_q <= sticky_uf_d;
      sticky_of_q <= sticky_of_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign exp_out   = s2_exp_q;
  assign uf        = s2_uf_q;
  assign of        = s2_of_q;
  assign sticky_uf = sticky_uf_q;
  assign sticky_of = sticky_of_q;

endmodule : exp_adjust_pipe

// File: tb/tb_exp_adjust_pipe.sv
// Directed self-checking bench for exp_adjust_pipe (EW=8, SW=5).
module tb_exp_adjust_pipe;
  import fpu_exp_pkg::*;

  localparam int unsigned EW = 8;
  localparam int unsigned SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] exp_in;
  logic [SW-1:0] shamt;
  logic          op;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] exp_out;
  logic          uf;
  logic          of;
  logic          sticky_uf;
  logic          sticky_of;
  logic          clr_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  exp_adjust_pipe #(.EW(EW), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .exp_in     (exp_in),
    .shamt      (shamt),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_out    (exp_out),
    .uf         (uf),
    .of         (of),
    .sticky_uf  (sticky_uf),
    .sticky_of  (sticky_of),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, wait (bounded) for acceptance, then drop in_valid.
  task automatic send(input logic [EW-1:0] e, input logic [SW-1:0] s, input logic o);
    int n;
    in_valid = 1'b1;
    exp_in   = e;
    shamt    = s;
    op       = o;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result with out_ready=1, check it, let it transfer.
  task automatic recv(input string tag, input logic [EW-1:0] e, input logic u, input logic o);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_exp"}, 32'(exp_out), 32'(e));
    check({tag, "_uf"}, 32'(uf), 32'(u));
    check({tag, "_of"}, 32'(of), 32'(o));
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    exp_in     = '0;
    shamt      = '0;
    op         = OP_SUB;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_exp_out", 32'(exp_out), 32'd0);
    check("rst_sticky", 32'({sticky_uf, sticky_of}), 32'd0);
    rst = 1'b0;
    tick();

    // 1: basic sub with latency check
    in_valid = 1'b1; exp_in = 8'h80; shamt = 5'd5; op = OP_SUB;
    check("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t1_lat1", 32'(out_valid), 32'd0);
    tick();
    check("t1_lat2", 32'(out_valid), 32'd1);
    check("t1_exp", 32'(exp_out), 32'h7B);
    check("t1_flags", 32'({uf, of}), 32'd0);
    tick();
    check("t1_drain", 32'(out_valid), 32'd0);

    // 2: underflow, sticky set then cleared
    send(8'h03, 5'd3, OP_SUB);
    recv("t2", 8'h00, 1'b1, 1'b0);
    check("t2_sticky_set", 32'(sticky_uf), 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("t2_sticky_clr", 32'(sticky_uf), 32'd0);

    // 3: add overflow and just-below-overflow
    send(8'hFC, 5'd4, OP_ADD);
    recv("t3a", 8'hFF, 1'b0, 1'b1);
    check("t3_sticky_of", 32'(sticky_of), 32'd1);
    send(8'hF0, 5'h0E, OP_ADD);
    recv("t3b", 8'hFE, 1'b0, 1'b0);

    // Boundaries: shamt=0 passes through; all-ones exponent always overflows
    send(8'h55, 5'd0, OP_SUB);
    recv("bnd_sub0", 8'h55, 1'b0, 1'b0);
    send(8'h55, 5'd0, OP_ADD);
    recv("bnd_add0", 8'h55, 1'b0, 1'b0);
    send(8'hFF, 5'd0, OP_ADD);
    recv("bnd_ff", 8'hFF, 1'b0, 1'b1);
    send(8'h00, 5'd31, OP_SUB);
    recv("bnd_borrow", 8'h00, 1'b1, 1'b0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;

    // 4: backpressure, two buffered, third stalled
    out_ready = 1'b0;
    send(8'h40, 5'd1, OP_SUB);
    send(8'h40, 5'd2, OP_SUB);
    in_valid = 1'b1; exp_in = 8'h40; shamt = 5'd3; op = OP_SUB;
    check("t4_stall_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("t4_stall_ready2", 32'(in_ready), 32'd0);
    check("t4_hold_valid", 32'(out_valid), 32'd1);
    check("t4_hold_exp", 32'(exp_out), 32'h3F);
    out_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(in_ready), 32'd1);
    check("t4_r0", 32'(exp_out), 32'h3F);
    tick();
    in_valid = 1'b0;
    check("t4_r1_valid", 32'(out_valid), 32'd1);
    check("t4_r1", 32'(exp_out), 32'h3E);
    tick();
    check("t4_r2_valid", 32'(out_valid), 32'd1);
    check("t4_r2", 32'(exp_out), 32'h3D);
    tick();
    check("t4_empty", 32'(out_valid), 32'd0);

    // 5: clear coincides with underflow transfer; set wins, other flag clears
    send(8'hFE, 5'd4, OP_ADD);
    recv("t5_of", 8'hFF, 1'b0, 1'b1);
    send(8'h00, 5'd0, OP_SUB);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    check("t5_uf", 32'(uf), 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("t5_sticky_uf", 32'(sticky_uf), 32'd1);
    check("t5_sticky_of", 32'(sticky_of), 32'd0);

    // 6: reset with two ops in flight
    out_ready = 1'b0;
    send(8'h10, 5'd1, OP_SUB);
    send(8'h20, 5'd1, OP_SUB);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_exp", 32'(exp_out), 32'd0);
    check("t6_rst_sticky", 32'(sticky_uf), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_stale", 32'(out_valid), 32'd0);
    end
    send(8'h20, 5'd1, OP_SUB);
    recv("t6_next", 8'h1F, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_exp_adjust_pipe
